// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter sizing helper.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter must be able to hold values 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's complement negation: out = en ? -in : in.
// Used for operand magnitudes and for re-applying the product sign.
module twos_negate #(
  parameter int N = 16
) (
  input  logic [N-1:0] in,
  input  logic         en,
  output logic [N-1:0] out
);

  assign out = en ? (~in + {{(N-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier retiring one multiplier bit per clock.
// Signed mode multiplies magnitudes and negates the 2*WIDTH product at the end.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] n
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic                 neg_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     n_r;

  logic                 accept_s;
  logic                 last_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   acc_step_s;
  logic [2*WIDTH-1:0]   prod_s;

  twos_negate #(.N(WIDTH)) u_neg_a (
    .in  (a),
    .en  (signed_mode & a[WIDTH-1]),
    .out (a_mag_s)
  );

  twos_negate #(.N(WIDTH)) u_neg_b (
    .in  (b),
    .en  (signed_mode & b[WIDTH-1]),
    .out (b_mag_s)
  );

  // The final product sign is applied to the accumulator value of the last iteration
  twos_negate #(.N(2*WIDTH)) u_neg_p (
    .in  (acc_step_s),
    .en  (neg_r),
    .out (prod_s)
  );

  assign accept_s   = (state_r == IDLE) & start;
  assign last_s     = (state_r == RUN) & (cnt_r == LAST_CNT);
  assign sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (mplier_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
  assign acc_step_s = {sum_s, acc_r[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = IDLE;
        else        state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Operand, accumulator, counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      m_r      <= {WIDTH{1'b0}};
      n_r      <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_s == RUN);
      if (accept_s) begin
        mcand_r  <= a_mag_s;
        mplier_r <= b_mag_s;
        acc_r    <= {(2*WIDTH){1'b0}};
        neg_r    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt_r    <= {CW{1'b0}};
      end else if (state_r == RUN) begin
        acc_r    <= acc_step_s;
        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        if (last_s) begin
          cnt_r  <= {CW{1'b0}};
          m_r    <= prod_s[WIDTH-1:0];
          n_r    <= prod_s[2*WIDTH-1:WIDTH];
          done_r <= 1'b1;
        end else begin
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign m    = m_r;
  assign n    = n_r;

endmodule
